// File: rtl/stream_width_downsizer_if.sv
// Valid/ready bundle for the width downsizer: a wide word stream in,
// a narrow beat stream out, plus the sticky protocol error flag.
interface stream_width_downsizer_if #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 8
);
    localparam int RATIO = IN_WIDTH / OUT_WIDTH;

    logic                 in_valid;
    logic                 in_ready;
    logic [IN_WIDTH-1:0]  in_data;
    logic [RATIO-1:0]     in_keep;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_WIDTH-1:0] out_data;
    logic                 out_last;
    logic                 protocol_err;

    // Downsizer side: consumes words, produces beats.
    modport slave (
        input  in_valid, in_data, in_keep, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, protocol_err
    );

    // Environment side: produces words, consumes beats.
    modport master (
        output in_valid, in_data, in_keep, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, protocol_err
    );
endinterface

// File: rtl/stream_width_downsizer.sv
// Splits each IN_WIDTH word into up to RATIO OUT_WIDTH beats, LS slice
// first. Beat count comes from the highest set keep bit; the word's last
// flag lands on its final beat. A new word loads in the same cycle the
// final beat of the current word is consumed, so full words stream with
// no bubbles. IN_WIDTH must be an integer multiple of OUT_WIDTH.
module stream_width_downsizer #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    stream_width_downsizer_if.slave bus
);
    localparam int RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t                          r_state;
    logic [RATIO-1:0][OUT_WIDTH-1:0] r_word;
    logic                            r_last;
    logic [IDX_W-1:0]                r_idx;
    logic [IDX_W-1:0]                r_lidx;     // index of final beat (n-1)
    logic                            r_out_valid;
    logic [OUT_WIDTH-1:0]            r_out_data;
    logic                            r_out_last;
    logic                            r_err;

    logic [RATIO-1:0][OUT_WIDTH-1:0] w_in_slices;
    logic [IDX_W-1:0]                w_lidx;
    logic [IDX_W-1:0]                w_nidx;
    logic                            w_keep_zero;
    logic                            w_beat;
    logic                            w_final;
    logic                            w_in_ready;
    logic                            w_accept;

    assign w_in_slices = bus.in_data;
    assign w_keep_zero = (bus.in_keep == '0);
    assign w_beat      = r_out_valid && bus.out_ready;
    assign w_final     = (r_idx == r_lidx);
    assign w_nidx      = r_idx + 1'b1;

    // Ready when idle or when the final beat leaves this cycle; held low in reset.
    assign w_in_ready  = !rst && (r_state == IDLE || (w_beat && w_final));
    assign w_accept    = bus.in_valid && w_in_ready;

    // Final beat index = position of the highest set keep bit (holes below still sent).
    always_comb begin
        w_lidx = '0;
        for (int k = 0; k < RATIO; k++) begin
            if (bus.in_keep[k]) w_lidx = IDX_W'(k);
        end
    end

    // Word/beat FSM with registered beat outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_word      <= '0;
            r_last      <= 1'b0;
            r_idx       <= '0;
            r_lidx      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_err       <= 1'b0;
        end else if (w_accept) begin
            if (w_keep_zero) begin
                // Empty word: swallowed, flagged, nothing emitted.
                r_state     <= IDLE;
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
                r_err       <= 1'b1;
            end else begin
                r_state     <= SEND;
                r_word      <= w_in_slices;
                r_last      <= bus.in_last;
                r_lidx      <= w_lidx;
                r_idx       <= '0;
                r_out_valid <= 1'b1;
                r_out_data  <= w_in_slices[0];
                r_out_last  <= bus.in_last && (w_lidx == '0);
            end
        end else if (w_beat) begin
            if (w_final) begin
                r_state     <= IDLE;
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end else begin
                r_idx       <= w_nidx;
                r_out_data  <= r_word[w_nidx];
                r_out_last  <= r_last && (w_nidx == r_lidx);
            end
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = r_out_valid;
    assign bus.out_data     = r_out_data;
    assign bus.out_last     = r_out_last;
    assign bus.protocol_err = r_err;
endmodule

// File: doc/stream_width_downsizer.md
Name: stream_width_downsizer

Overview:
- Valid/ready stream stage that sits directly downstream of the single-entry pipeline register.
- Accepts one IN_WIDTH word per handshake and emits it as up to RATIO narrower OUT_WIDTH beats, least-significant slice first.
- Per-word keep mask trims partial words; a last marker is propagated onto the final emitted beat.
- Zero-bubble: a new word is accepted in the same cycle the final beat of the current word is consumed.

Parameters:
- IN_WIDTH, 32, input word width; must be an integer multiple of OUT_WIDTH.
- OUT_WIDTH, 8, output beat width.
- RATIO, IN_WIDTH/OUT_WIDTH (derived localparam, 4 by default), maximum beats per word.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  block can take a word this cycle.
- in_data  in  IN_WIDTH  upstream word; slice k = bits [k*OUT_WIDTH +: OUT_WIDTH].
- in_keep  in  RATIO  slice-valid mask, bit k qualifies slice k.
- in_last  in  1  word is the final word of a packet.
- out_valid  out  1  beat valid.
- out_ready  in  1  downstream accepts beat.
- out_data  out  OUT_WIDTH  current beat.
- out_last  out  1  final beat of a word that carried in_last.
- protocol_err  out  1  sticky flag: a word with in_keep == 0 was accepted.

Behaviour:
- Reset (rst high at a clock edge): busy=0, beat index=0, holding regs cleared; out_valid=0, out_data=0, out_last=0, protocol_err=0. in_ready is forced 0 during any cycle in which rst is high; it is 1 in the first cycle after rst deasserts.
- Reset mid-word discards the held word and its remaining beats; nothing is emitted afterwards for that word.
- State: IDLE (busy=0), SEND (busy=1, beat index idx, beat count n, held word, held last).
- Beat count on acceptance: n = (index of highest set bit of in_keep) + 1. Holes below the highest set bit are still emitted, as the raw slice contents. Legal keep is LSB-contiguous.
- in_ready = !busy || (out_valid && out_ready && idx == n-1). Purely combinational from state and out_ready; does not depend on in_valid.
- Word acceptance (in_valid && in_ready):
  - Word, n and in_last are captured; idx = 0.
  - out_valid rises the next cycle, giving 1-cycle latency from acceptance to the first beat.
- Output signals:
  - out_valid = busy.
  - out_data = held slice idx, registered; it is stable while out_valid && !out_ready.
  - out_last = held_last && idx == n-1.
- Beat handshake (out_valid && out_ready):
  - If idx < n-1: idx increments.
  - Else (final beat): if a word is accepted in the same cycle, the new word loads with idx=0 and busy stays 1; otherwise busy=0.
- Throughput: a full word (n=RATIO) with out_ready held high produces RATIO beats on consecutive cycles, with no gap between words.
- in_keep == 0 on acceptance:
  - The word is consumed and dropped; no beats are emitted, including when in_last=1.
  - protocol_err is set and stays set until rst.
  - busy stays 0, or becomes 0 if this word replaced a finishing word.
- out_valid must never drop and out_data must never change without a handshake; downstream backpressure of any length is tolerated.
- in_data, in_keep and in_last are sampled only on acceptance.

Test Plan:
- Reset, then in_data=0xDDCCBBAA, keep=4'b1111, last=1, out_ready=1 -> beats AA,BB,CC,DD on 4 consecutive cycles starting 1 cycle after acceptance; out_last=1 only on DD; in_ready=0 during AA..CC and 1 during DD.
- Two back-to-back full words 0x03020100 and 0x07060504, out_ready=1 -> 8 beats 00..07 on 8 consecutive cycles with no bubble; the second word is accepted in the cycle beat 03 is consumed.
- keep=4'b0011, data=0x11223344, last=1 -> beats 44, 33 (out_last on 33); keep=4'b0101, data=0xA1B2C3D4 -> 3 beats D4, C3, B2.
- Word 0xCAFEF00D with out_ready toggling 1,0,0,1,0,1,1 -> out_data holds its value while stalled; the beat sequence is exactly 0D, F0, FE, CA.
- keep=4'b0000, last=1 -> word accepted, no out_valid, protocol_err=1 and staying 1 across later legal words until rst.
- rst pulsed for 1 cycle after beat 2 of 0x44332211 -> out_valid=0 and protocol_err=0 the next cycle, in_ready=0 during rst, remaining beats 33 and 44 are never emitted.
